// File: rtl/axi_stride_reader_pkg.sv
// Shared prefetcher definitions: sequencer states, response error codes and counter widths.
// Imported by the stride reader top and its response checker.
package axi_stride_reader_pkg;

    localparam int COUNT_WIDTH    = 16;
    localparam int BEAT_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_ID_MISMATCH  = 2'd1,
        ERR_EARLY_LAST   = 2'd2,
        ERR_MISSING_LAST = 2'd3
    } err_code_t;

    // The read channel is open only while a sequence is live.
    function automatic logic is_busy(input state_t s);
        return (s == ISSUE) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/axi_stride_reader_if.sv
// AXI read-address and read-data channel bundle between the stride reader (master)
// and the memory side (slave).
interface axi_stride_reader_if #(
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 4,
    parameter int DATA_BITS       = 64
);
    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH-1:0]       m_ar_id;

    logic                       m_r_valid;
    logic                       m_r_ready;
    logic [DATA_BITS-1:0]       m_r_data;
    logic                       m_r_last;
    logic [TID_WIDTH-1:0]       m_r_id;

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
        input  m_ar_ready,
        input  m_r_valid, m_r_data, m_r_last, m_r_id,
        output m_r_ready
    );

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
        output m_ar_ready,
        output m_r_valid, m_r_data, m_r_last, m_r_id,
        input  m_r_ready
    );

endinterface

// File: rtl/axi_stride_reader_r_checker.sv
// Per-beat read response checker: tracks the beat index inside the current burst and
// records the first protocol error seen since the last sequence start.
module axi_r_checker
    import axi_stride_reader_pkg::*;
#(
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       clear,
    input  logic                       beat,
    input  logic                       r_last,
    input  logic [TID_WIDTH-1:0]       r_id,
    input  logic [TID_WIDTH-1:0]       exp_id,
    input  logic [BURST_LEN_WIDTH-1:0] burst_len,
    output err_code_t                  error_code
);

    localparam int IDX_W = BURST_LEN_WIDTH + 1;

    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W-1:0] last_idx;
    err_code_t        beat_err;

    assign last_idx = {1'b0, burst_len};

    // An ID mismatch outranks a framing error when both hit the same beat.
    always_comb begin
        beat_err = ERR_NONE;
        if (r_id != exp_id) begin
            beat_err = ERR_ID_MISMATCH;
        end else if (r_last && (beat_idx < last_idx)) begin
            beat_err = ERR_EARLY_LAST;
        end else if (!r_last && (beat_idx == last_idx)) begin
            beat_err = ERR_MISSING_LAST;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            beat_idx   <= '0;
            error_code <= ERR_NONE;
        end else if (clear) begin
            beat_idx   <= '0;
            error_code <= ERR_NONE;
        end else if (beat) begin
            if (r_last) begin
                beat_idx <= '0;
            end else if (beat_idx != '1) begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
            if (error_code == ERR_NONE) begin
                error_code <= beat_err;
            end
        end
    end

endmodule

// File: rtl/axi_stride_reader.sv
// Strided AXI read sequencer: issues reqCount bursts at baseAddr + n*stride, bounds the
// number of bursts in flight and counts/checks the returning beats.
module axi_stride_reader
    import axi_stride_reader_pkg::*;
#(
    parameter int ADDR_BITS            = 64,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 4,
    parameter int LOG_BLOCK_DATA_BYTES = 3,
    parameter int LOG_MAX_OUTSTANDING  = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       baseAddr,
    input  logic [ADDR_BITS-1:0]       stride,
    input  logic [COUNT_WIDTH-1:0]     reqCount,
    input  logic [BURST_LEN_WIDTH-1:0] burstLen,
    input  logic [TID_WIDTH-1:0]       reqId,
    axi_stride_reader_if.master        axi,
    output logic                       busy,
    output logic                       done,
    output logic [BEAT_CNT_WIDTH-1:0]  beatCnt,
    output logic [1:0]                 errorCode
);

    localparam int DATA_BITS = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int OUT_W     = LOG_MAX_OUTSTANDING + 1;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(1) << LOG_MAX_OUTSTANDING;

    state_t                     state;
    state_t                     next_state;
    logic [ADDR_BITS-1:0]       cur_addr;
    logic [ADDR_BITS-1:0]       cfg_stride;
    logic [COUNT_WIDTH-1:0]     cfg_count;
    logic [BURST_LEN_WIDTH-1:0] cfg_len;
    logic [TID_WIDTH-1:0]       cfg_id;
    logic [COUNT_WIDTH-1:0]     issued;
    logic [OUT_W-1:0]           outstanding;
    logic [BEAT_CNT_WIDTH-1:0]  beat_cnt;

    logic      start_accept;
    logic      ar_fire;
    logic      r_fire;
    logic      last_fire;
    err_code_t chk_err;
    logic      unused_rdata;

    assign start_accept = (state == IDLE) && start;
    assign ar_fire      = axi.m_ar_valid && axi.m_ar_ready;
    assign r_fire       = axi.m_r_valid && axi.m_r_ready;
    assign last_fire    = r_fire && axi.m_r_last;

    // Valid depends only on registered state, so it cannot drop while waiting for ready.
    assign axi.m_ar_valid = (state == ISSUE) && (issued < cfg_count) && (outstanding < MAX_OUT);
    assign axi.m_ar_addr  = cur_addr;
    assign axi.m_ar_len   = cfg_len;
    assign axi.m_ar_id    = cfg_id;
    assign axi.m_r_ready  = is_busy(state);

    assign busy      = is_busy(state);
    assign done      = (state == FINISH);
    assign beatCnt   = beat_cnt;
    assign errorCode = chk_err;

    // Read data is consumed by the prefetch buffer downstream; only the handshake matters here.
    assign unused_rdata = ^{1'b0, axi.m_r_data[DATA_BITS-1:0]};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = (reqCount == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (ar_fire && ((issued + COUNT_WIDTH'(1)) == cfg_count)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cfg_stride <= '0;
            cfg_count  <= '0;
            cfg_len    <= '0;
            cfg_id     <= '0;
            cur_addr   <= '0;
            issued     <= '0;
        end else if (start_accept) begin
            cfg_stride <= stride;
            cfg_count  <= reqCount;
            cfg_len    <= burstLen;
            cfg_id     <= reqId;
            cur_addr   <= baseAddr;
            issued     <= '0;
        end else if (ar_fire) begin
            cur_addr <= cur_addr + cfg_stride;
            issued   <= issued + COUNT_WIDTH'(1);
        end
    end

    // A new burst and a retiring burst in the same cycle cancel out.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outstanding <= '0;
        end else if (start_accept) begin
            outstanding <= '0;
        end else if (ar_fire && !last_fire) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!ar_fire && last_fire && (outstanding != '0)) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            beat_cnt <= '0;
        end else if (start_accept) begin
            beat_cnt <= '0;
        end else if (r_fire) begin
            beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
        end
    end

    axi_r_checker #(
        .BURST_LEN_WIDTH (BURST_LEN_WIDTH),
        .TID_WIDTH       (TID_WIDTH)
    ) u_r_checker (
        .clk        (clk),
        .resetN     (resetN),
        .clear      (start_accept),
        .beat       (r_fire),
        .r_last     (axi.m_r_last),
        .r_id       (axi.m_r_id),
        .exp_id     (cfg_id),
        .burst_len  (cfg_len),
        .error_code (chk_err)
    );

endmodule
